instruction_queue: RTL and testbench



---
 rtl/instruction_queue.sv | 61 ++++++
 tb/tb_instruction_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// In-order instruction queue between instruction memory and the controller.
// Presents the oldest word split into opcode and data fields; flush discards all entries.
module instruction_queue #(
  parameter int unsigned INSTR_WIDTH  = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [INSTR_WIDTH-1:0]              instruction,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  output logic [OPCODE_WIDTH-1:0]             opcode,
  output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] data,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic                                flush,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int unsigned DATA_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int unsigned PTR_WIDTH  = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [INSTR_WIDTH-1:0] head;
  logic                   push;
  logic                   pop;

  // Handshake status comes only from the registered occupancy.
  assign instr_ready = (count != CNT_WIDTH'(DEPTH));
  assign out_valid   = (count != '0);
  assign push        = instr_valid && instr_ready;
  assign pop         = out_valid && out_ready;

  assign head   = mem[rd_ptr];
  assign opcode = out_valid ? head[INSTR_WIDTH-1 -: OPCODE_WIDTH] : '0;
  assign data   = out_valid ? head[DATA_WIDTH-1:0] : '0;

  // Pointer and occupancy state; reset beats flush, flush discards the cycle's handshakes.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
    end
  end

  // Storage is not reset; only accepted pushes write it.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) mem[wr_ptr] <= instruction;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a queue-based scoreboard of expected words.
module tb_instruction_queue;

  localparam int unsigned IW    = 8;
  localparam int unsigned OW    = 4;
  localparam int unsigned DW    = IW - OW;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] opcode;
  logic [DW-1:0] data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [IW-1:0] sb[$];

  instruction_queue #(.INSTR_WIDTH(IW), .OPCODE_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .data(data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst, input logic iv, input logic [IW-1:0] ins,
                      input logic ordy, input logic fl);
    logic [IW-1:0] hd;
    logic exp_valid, exp_ready, do_push, do_pop;
    reset = rst; instr_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
    @(negedge clock);
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() != DEPTH);
    hd = exp_valid ? sb[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
    chk("count", 32'(count), 32'(sb.size()));
    chk("opcode", 32'(opcode), 32'(hd[IW-1 -: OW]));
    chk("data", 32'(data), 32'(hd[DW-1:0]));
    do_pop  = exp_valid && ordy && !rst && !fl;
    do_push = iv && exp_ready && !rst && !fl;
    @(posedge clock);
    #1;
    if (rst || fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(ins);
    end
  endtask

  initial begin
    // Reset for two cycles with a valid word presented: nothing may be stored.
    reset = 1'b1; instr_valid = 1'b1; instruction = 8'hA5; out_ready = 1'b0; flush = 1'b0;
    @(posedge clock);
    #1;
    step(1, 1, 8'hA5, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Single push then pop, with one-cycle latency.
    step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // All-zero word is a legal entry.
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Fill, refuse a push while full even with a pop, then drain in order.
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    step(0, 1, 8'h44, 0, 0);
    step(0, 1, 8'h55, 1, 0);
    chk("overflow_count", 32'(count), 32'd3);
    step(0, 1, 8'h55, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Streaming across pointer wrap: count stays at one.
    step(0, 1, 8'h01, 0, 0);
    for (int k = 2; k <= 10; k++) begin
      step(0, 1, IW'(k), 1, 0);
      chk("stream_count", 32'(count), 32'd1);
    end
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Flush with three entries while pushing and popping; flushed push must vanish.
    step(0, 1, 8'hAA, 0, 0);
    step(0, 1, 8'hBB, 0, 0);
    step(0, 1, 8'hCC, 0, 0);
    step(0, 1, 8'h77, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    step(0, 1, 8'h88, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Reset mid-stream discards entries and completes no handshake.
    step(0, 1, 8'hD1, 0, 0);
    step(0, 1, 8'hD2, 0, 0);
    step(1, 1, 8'hD3, 1, 0);
    step(0, 1, 8'hE4, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
